// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mult_pkg;

  // Control states of the multiplier.
  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  // Radix-2 Booth actions, indexed by {Q[0], Q_-1}.
  localparam logic [1:0] BoothNop0 = 2'b00;
  localparam logic [1:0] BoothAdd  = 2'b01;
  localparam logic [1:0] BoothSub  = 2'b10;
  localparam logic [1:0] BoothNop1 = 2'b11;

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: conditional add/sub of M into A,
// followed by an arithmetic right shift of {A, Q, Q_-1}.
module booth_step
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH+1:0] i_acc,
  input  logic [WIDTH:0]   i_q,
  input  logic             i_q_m1,
  input  logic [WIDTH:0]   i_m,
  output logic [WIDTH+1:0] o_acc,
  output logic [WIDTH:0]   o_q,
  output logic             o_q_m1
);

  logic [WIDTH+1:0] w_m_ext;
  logic [WIDTH+1:0] w_sum;

  // M is already WIDTH+1 bits in two's complement; widen it to accumulator size.
  assign w_m_ext = {i_m[WIDTH], i_m};

  // Select the Booth action from the current multiplier bit pair.
  always_comb begin
    w_sum = i_acc;
    case ({i_q[0], i_q_m1})
      BoothAdd:  w_sum = i_acc + w_m_ext;
      BoothSub:  w_sum = i_acc - w_m_ext;
      BoothNop0: w_sum = i_acc;
      BoothNop1: w_sum = i_acc;
      default:   w_sum = i_acc;
    endcase
  end

  // Arithmetic right shift of the concatenated {A, Q, Q_-1}.
  assign o_acc  = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
  assign o_q    = {w_sum[0], i_q[WIDTH:1]};
  assign o_q_m1 = i_q[0];

endmodule

// File: rtl/seq_multiplier.sv
// Sequential signed/unsigned multiplier built on a radix-2 Booth datapath.
// Operands are widened by one bit so a single signed datapath covers both modes.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(WIDTH + 2);

  state_e r_state;
  state_e w_state_next;

  logic [WIDTH+1:0]   r_acc;
  logic [WIDTH:0]     r_q;
  logic               r_q_m1;
  logic [WIDTH:0]     r_m;
  logic [CntW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic               w_capture;
  logic               w_last_step;
  logic [WIDTH:0]     w_a_ext;
  logic [WIDTH:0]     w_b_ext;
  logic [WIDTH+1:0]   w_acc_nx;
  logic [WIDTH:0]     w_q_nx;
  logic               w_q_m1_nx;

  // New work is only accepted outside CALC; a start during CALC is dropped.
  assign w_capture   = start && ((r_state == StIdle) || (r_state == StDone));
  assign w_last_step = (r_state == StCalc) && (r_cnt == '0);

  assign w_a_ext = {signed_mode & a[WIDTH-1], a};
  assign w_b_ext = {signed_mode & b[WIDTH-1], b};

  booth_step #(
    .WIDTH (WIDTH)
  ) u_booth_step (
    .i_acc  (r_acc),
    .i_q    (r_q),
    .i_q_m1 (r_q_m1),
    .i_m    (r_m),
    .o_acc  (w_acc_nx),
    .o_q    (w_q_nx),
    .o_q_m1 (w_q_m1_nx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StCalc;
      StCalc:  if (r_cnt == '0) w_state_next = StDone;
      StDone:  w_state_next = start ? StCalc : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Operand capture, Booth iteration and step counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_q    <= '0;
      r_q_m1 <= 1'b0;
      r_m    <= '0;
      r_cnt  <= '0;
    end else if (w_capture) begin
      r_acc  <= '0;
      r_q    <= w_b_ext;
      r_q_m1 <= 1'b0;
      r_m    <= w_a_ext;
      r_cnt  <= CntW'(WIDTH);
    end else if (r_state == StCalc) begin
      r_acc  <= w_acc_nx;
      r_q    <= w_q_nx;
      r_q_m1 <= w_q_m1_nx;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Product register: written only as the final step completes, so an aborted
  // operation never leaves a partial result behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_product <= '0;
    end else if (w_last_step) begin
      r_product <= {w_acc_nx[WIDTH-2:0], w_q_nx};
    end
  end

  assign busy    = (r_state == StCalc);
  assign done    = (r_state == StDone);
  assign product = r_product;

endmodule
